// File: rtl/bus_pkg.sv
// Shared CPU bus constants: responder window bases, excluded I/O page, responder FSM states.
// Pure declarations; no timing or flow-control behaviour.
package bus_pkg;

    localparam logic [15:0] BRAM_BASE_HIGH  = 16'h0000;
    localparam logic [15:0] TEXT_BASE_HIGH  = 16'h1000;
    localparam logic [15:0] PSRAM_BASE_HIGH = 16'h4000;
    localparam logic [7:0]  IO_PAGE         = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        WAIT_LOW
    } rsp_state_t;

endpackage

// File: rtl/bram_sp32.sv
// Single-port 32-bit RAM: synchronous write, read data registered one cycle after en_i.
// Indices at or beyond WORDS read as zero and drop writes; no backpressure.
module bram_sp32 #(
    parameter int    WORDS     = 16384,
    parameter string INIT_FILE = ""
) (
    input  logic        clk_i,
    input  logic        en_i,
    input  logic        we_i,
    input  logic [13:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] mem [0:WORDS-1];
    logic [31:0] rdata_q;
    logic        in_range;

    assign in_range = ({18'd0, addr_i} < 32'(WORDS));
    assign rdata_o  = rdata_q;

    // Zero fill only; contents are never touched by reset.
    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i && in_range) begin
                mem[addr_i[AW-1:0]] <= wdata_i;
            end
            rdata_q <= in_range ? mem[addr_i[AW-1:0]] : 32'd0;
        end
    end

endmodule

// File: rtl/bram_bus_responder.sv
// BRAM responder for the CPU bus: syncs the foreign-domain strobe, decodes, runs one RAM access per rise.
// Ready 5 edges after the strobe is first sampled high, held until 3 edges after it is sampled low.
module bram_bus_responder #(
    parameter logic [15:0] BASE_HIGH = bus_pkg::BRAM_BASE_HIGH,
    parameter logic [7:0]  IO_PAGE   = bus_pkg::IO_PAGE,
    parameter int          WORDS     = 16384,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk_100mhz,
    input  logic        rstn_i,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_cs,
    output logic [31:0] o_data,
    output logic        o_data_ready,
    output logic        o_busy
);

    import bus_pkg::*;

    rsp_state_t  state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic [13:0] idx_q, idx_d;
    logic        we_q, we_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] data_q, data_d;
    logic        rdy_q, rdy_d;
    logic [31:0] out_data_q;
    logic        out_rdy_q;
    logic        ram_en, ram_we;
    logic [31:0] ram_rdata;
    logic        rise;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^i_addr[1:0];
    assign o_cs            = (i_addr[31:16] == BASE_HIGH) && (i_addr[15:8] != IO_PAGE);
    assign rise            = s2_q & ~s3_q;
    assign o_busy          = (state_q != IDLE);
    assign o_data          = out_data_q;
    assign o_data_ready    = out_rdy_q;

    bram_sp32 #(
        .WORDS     (WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk_100mhz),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (idx_q),
        .wdata_i (wdat_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && o_cs) begin
                    idx_d   = i_addr[15:2];
                    we_d    = i_we;
                    wdat_d  = i_data;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_en  = 1'b1;
                ram_we  = we_q;
                state_d = RESP;
            end
            RESP: begin
                data_d = we_q ? wdat_q : ram_rdata;
                // A strobe withdrawn before completion gets no ready; the write has still landed.
                if (s2_q) begin
                    rdy_d   = 1'b1;
                    state_d = WAIT_LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!s2_q) begin
                    rdy_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            wdat_q     <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
            out_data_q <= '0;
            out_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= i_stb;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            idx_q      <= idx_d;
            we_q       <= we_d;
            wdat_q     <= wdat_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
            // Final retiming stage so the read-return mux sees clean flop outputs.
            out_data_q <= data_q;
            out_rdy_q  <= rdy_q;
        end
    end

endmodule
